// File: rtl/key_debounce.sv
// key_debounce: per-key two-flop synchroniser followed by a debounce FSM.
// Each channel produces a clean level and a one-cycle strobe on every accepted press.
// A new level is accepted only after the synchronised key has disagreed with the
// current level for DEBOUNCE_CYCLES+1 consecutive samples. Any agreeing sample
// restarts the window.
module key_debounce #(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              set,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_pulse
);

  // Width is chosen so that DEBOUNCE_CYCLES-1 always fits. The counter never goes past it.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CHK_PRESS = 2'd1;
  localparam logic [1:0] ST_DOWN      = 2'd2;
  localparam logic [1:0] ST_CHK_REL   = 2'd3;

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_chan
    logic             r_sync1;
    logic             r_key_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    logic [1:0]       w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_level_d;
    logic             w_pulse_d;

    // Two-flop synchroniser. Only r_key_s is visible to the FSM.
    always_ff @(posedge clk) begin
      if (set) begin
        r_sync1 <= 1'b0;
        r_key_s <= 1'b0;
      end else begin
        r_sync1 <= key[g];
        r_key_s <= r_sync1;
      end
    end

    // Debounce FSM next state. The pulse defaults low, so it lasts exactly one cycle.
    always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_level_d = r_level;
      w_pulse_d = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_level_d = 1'b0;
          if (r_key_s) begin
            w_state_d = ST_CHK_PRESS;
            w_cnt_d   = '0;
          end
        end
        ST_CHK_PRESS: begin
          w_level_d = 1'b0;
          if (!r_key_s) begin
            // Bounce: drop the attempt and give no partial credit.
            w_state_d = ST_IDLE;
            w_cnt_d   = '0;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_d = r_cnt + CNT_ONE;
          end else begin
            w_state_d = ST_DOWN;
            w_level_d = 1'b1;
            w_pulse_d = 1'b1;
          end
        end
        ST_DOWN: begin
          w_level_d = 1'b1;
          if (!r_key_s) begin
            w_state_d = ST_CHK_REL;
            w_cnt_d   = '0;
          end
        end
        ST_CHK_REL: begin
          w_level_d = 1'b1;
          if (r_key_s) begin
            w_state_d = ST_DOWN;
            w_cnt_d   = '0;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_d = r_cnt + CNT_ONE;
          end else begin
            // Accepted release: the level drops, with no strobe.
            w_state_d = ST_IDLE;
            w_level_d = 1'b0;
          end
        end
        default: begin
          w_state_d = ST_IDLE;
          w_cnt_d   = '0;
          w_level_d = 1'b0;
        end
      endcase
    end

    // FSM, counter and output registers. Reset overrides everything else.
    always_ff @(posedge clk) begin
      if (set) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_d;
        r_cnt   <= w_cnt_d;
        r_level <= w_level_d;
        r_pulse <= w_pulse_d;
      end
    end

    assign key_level[g] = r_level;
    assign key_pulse[g] = r_pulse;
  end

endmodule
